// File: rtl/sync_fifo_pkg.sv
// Shared defaults and elaboration helpers for the parametrised synchronous FIFO.
package sync_fifo_pkg;
  localparam int DW_DEF    = 8;
  localparam int DEPTH_DEF = 8;

  // Pointer wrap arithmetic relies on DEPTH being a power of two.
  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction
endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x DW storage: one write port, one registered read port, no reset.
module sync_fifo_mem #(
  parameter int DW    = 8,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with fill count, almost flags and read-valid strobe.
// Define FIFO_ERR_EN to enable the sticky overflow/underflow flags.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int AW     = $clog2(DEPTH),
  parameter int AF_LVL = DEPTH - 1,
  parameter int AE_LVL = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic [DW-1:0] d_in,
  input  logic          rd,
  output logic [DW-1:0] d_out,
  output logic          rd_valid,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow
);
  localparam int CW = AW + 1;

  if (!is_pow2(DEPTH)) begin : g_depth_chk
    $error("sync_fifo_param: DEPTH must be a power of two >= 2");
  end

  logic [AW:0]   wr_ptr, rd_ptr, wr_nxt, rd_nxt, cnt_q;
  logic          wr_ok, rd_ok, rv_q, rd_seen;
  logic [DW-1:0] mem_q;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign wr_ok  = wr && !full;
  assign rd_ok  = rd && !empty;
  assign wr_nxt = wr_ptr + {{AW{1'b0}}, wr_ok};
  assign rd_nxt = rd_ptr + {{AW{1'b0}}, rd_ok};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt_q   <= '0;
      rv_q    <= 1'b0;
      rd_seen <= 1'b0;
    end else begin
      wr_ptr  <= wr_nxt;
      rd_ptr  <= rd_nxt;
      cnt_q   <= wr_nxt - rd_nxt;
      rv_q    <= rd_ok;
      rd_seen <= rd_seen | rd_ok;
    end
  end

  sync_fifo_mem #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (d_in),
    .re    (rd_ok),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (mem_q)
  );

  // Storage has no reset, so d_out reads as zero until the first accepted read.
  assign d_out        = rd_seen ? mem_q : '0;
  assign rd_valid     = rv_q;
  assign count        = cnt_q;
  assign almost_full  = (cnt_q >= CW'(AF_LVL));
  assign almost_empty = (cnt_q <= CW'(AE_LVL));

`ifdef FIFO_ERR_EN
  logic ovf_q, unf_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | (wr && full);
      unf_q <= unf_q | (rd && empty);
    end
  end
  assign overflow  = ovf_q;
  assign underflow = unf_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif
endmodule
